rob_retire: RTL and testbench

//  In-order reorder buffer and retire stage: the release end of the physical-register free-pool protocol.

---
 rtl/rob_retire_pkg.sv | 28 ++
 rtl/rob_retire_ptr_ctrl.sv | 47 ++++
 rtl/rob_retire.sv | 146 ++++++++++++++
 tb/tb_rob_retire.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_retire_pkg.sv
// Shared widths, entry payload layout and the free-pool release rule for the
// reorder buffer / retire stage.
package rob_retire_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int IDX_WIDTH  = $clog2(ROB_DEPTH);
    localparam int PREG_WIDTH = 6;
    localparam int AREG_WIDTH = 5;

    typedef logic [IDX_WIDTH-1:0]  rob_idx_t;
    typedef logic [IDX_WIDTH:0]    rob_ptr_t;
    typedef logic [AREG_WIDTH-1:0] areg_t;
    typedef logic [PREG_WIDTH-1:0] preg_t;

    // Fields captured at dispatch; valid/done live in separate flop vectors.
    typedef struct packed {
        logic  reg_write;
        areg_t rd;
        preg_t rrd;
        preg_t old_tag;
    } rob_payload_t;

    // x0 is never renamed, so its old mapping must not be returned to the pool.
    function automatic logic frees_old_tag(input rob_payload_t e);
        return e.reg_write && (e.rd != '0);
    endfunction

endpackage

// File: rtl/rob_retire_ptr_ctrl.sv
// Head/tail pointer pair with wrap bit; derives full, empty and occupancy
// purely from registered pointer state.
module rob_ptr_ctrl
    import rob_retire_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    output logic [IDX_WIDTH:0]   head_o,
    output logic [IDX_WIDTH:0]   tail_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [IDX_WIDTH:0]   count_o
);

    rob_ptr_t head_q, head_d;
    rob_ptr_t tail_q, tail_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (push_i) tail_d = tail_q + rob_ptr_t'(1);
        if (pop_i)  head_d = head_q + rob_ptr_t'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the combinational next-state block above uses blocking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Same index with differing wrap bits means the tail has lapped the head.
    assign full_o  = (head_q[IDX_WIDTH-1:0] == tail_q[IDX_WIDTH-1:0]) &&
                     (head_q[IDX_WIDTH] != tail_q[IDX_WIDTH]);
    assign empty_o = (head_q == tail_q);
    assign count_o = tail_q - head_q;
    assign head_o  = head_q;
    assign tail_o  = tail_q;

endmodule

// File: rtl/rob_retire.sv
// In-order reorder buffer: records renamed instructions, collects out-of-order
// completions and retires one per cycle, returning superseded physical regs.
module rob_retire
    import rob_retire_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_valid,
    input  logic                  disp_reg_write,
    input  logic [AREG_WIDTH-1:0] disp_rd,
    input  logic [PREG_WIDTH-1:0] disp_rrd,
    input  logic [PREG_WIDTH-1:0] disp_old_tag,
    output logic                  disp_ready,
    output logic [IDX_WIDTH-1:0]  disp_rob_idx,
    input  logic                  cmpl0_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl0_idx,
    input  logic                  cmpl1_valid,
    input  logic [IDX_WIDTH-1:0]  cmpl1_idx,
    output logic                  push_free_reg,
    output logic [PREG_WIDTH-1:0] freed_reg,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_rd,
    output logic [PREG_WIDTH-1:0] retire_rrd,
    output logic                  empty,
    output logic [IDX_WIDTH:0]    count
);

    logic [ROB_DEPTH-1:0] valid_q, valid_d;
    logic [ROB_DEPTH-1:0] done_q,  done_d;
    rob_payload_t         payload_q [ROB_DEPTH];

    rob_ptr_t     head_ptr, tail_ptr;
    rob_idx_t     head_idx, tail_idx;
    logic         full;
    logic         disp_accept;
    logic         retire_fire;
    rob_payload_t head_entry;
    rob_payload_t disp_entry;

    logic  retire_valid_q, retire_valid_d;
    areg_t retire_rd_q,    retire_rd_d;
    preg_t retire_rrd_q,   retire_rrd_d;
    logic  push_free_q,    push_free_d;
    preg_t freed_reg_q,    freed_reg_d;

    rob_ptr_ctrl u_ptr_ctrl (
        .clk     (clk),
        .rst     (rst),
        .push_i  (disp_accept),
        .pop_i   (retire_fire),
        .head_o  (head_ptr),
        .tail_o  (tail_ptr),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign head_idx     = head_ptr[IDX_WIDTH-1:0];
    assign tail_idx     = tail_ptr[IDX_WIDTH-1:0];
    assign disp_ready   = !full;
    assign disp_rob_idx = tail_idx;
    assign disp_accept  = disp_valid && !full;
    assign retire_fire  = valid_q[head_idx] && done_q[head_idx];
    assign head_entry   = payload_q[head_idx];

    assign disp_entry = '{
        reg_write: disp_reg_write,
        rd:        disp_rd,
        rrd:       disp_rrd,
        old_tag:   disp_old_tag
    };

    // Completions only mark live entries, so a completion aimed at the slot
    // being dispatched this cycle is dropped (that slot is still invalid).
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (cmpl0_valid && valid_q[cmpl0_idx]) done_d[cmpl0_idx] = 1'b1;
        if (cmpl1_valid && valid_q[cmpl1_idx]) done_d[cmpl1_idx] = 1'b1;
        if (retire_fire) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
        end
        if (disp_accept) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // NOTE: payload storage has no reset; valid_q gates every read, so stale
    // contents are never observed and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (disp_accept) payload_q[tail_idx] <= disp_entry;
    end

    always_comb begin
        retire_valid_d = retire_fire;
        retire_rd_d    = '0;
        retire_rrd_d   = '0;
        push_free_d    = 1'b0;
        freed_reg_d    = '0;
        if (retire_fire) begin
            retire_rd_d  = head_entry.rd;
            retire_rrd_d = head_entry.rrd;
            if (frees_old_tag(head_entry)) begin
                push_free_d = 1'b1;
                freed_reg_d = head_entry.old_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_valid_q <= 1'b0;
            retire_rd_q    <= '0;
            retire_rrd_q   <= '0;
            push_free_q    <= 1'b0;
            freed_reg_q    <= '0;
        end else begin
            retire_valid_q <= retire_valid_d;
            retire_rd_q    <= retire_rd_d;
            retire_rrd_q   <= retire_rrd_d;
            push_free_q    <= push_free_d;
            freed_reg_q    <= freed_reg_d;
        end
    end

    assign retire_valid  = retire_valid_q;
    assign retire_rd     = retire_rd_q;
    assign retire_rrd    = retire_rrd_q;
    assign push_free_reg = push_free_q;
    assign freed_reg     = freed_reg_q;

endmodule

// File: tb/tb_rob_retire.sv
// Scenario bench for rob_retire: dispatches push expected retire records to a
// scoreboard that a negedge monitor pops and compares against retire pulses.
module tb_rob_retire;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [4:0] rd;
        logic [5:0] rrd;
        logic       push;
        logic [5:0] freed;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       disp_valid = 1'b0;
    logic       disp_reg_write = 1'b0;
    logic [4:0] disp_rd = '0;
    logic [5:0] disp_rrd = '0;
    logic [5:0] disp_old_tag = '0;
    logic       disp_ready;
    logic [3:0] disp_rob_idx;
    logic       cmpl0_valid = 1'b0;
    logic [3:0] cmpl0_idx = '0;
    logic       cmpl1_valid = 1'b0;
    logic [3:0] cmpl1_idx = '0;
    logic       push_free_reg;
    logic [5:0] freed_reg;
    logic       retire_valid;
    logic [4:0] retire_rd;
    logic [5:0] retire_rrd;
    logic       empty;
    logic [4:0] count;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    rob_retire dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_reg_write(disp_reg_write),
        .disp_rd(disp_rd), .disp_rrd(disp_rrd), .disp_old_tag(disp_old_tag),
        .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
        .cmpl0_valid(cmpl0_valid), .cmpl0_idx(cmpl0_idx),
        .cmpl1_valid(cmpl1_valid), .cmpl1_idx(cmpl1_idx),
        .push_free_reg(push_free_reg), .freed_reg(freed_reg),
        .retire_valid(retire_valid), .retire_rd(retire_rd), .retire_rrd(retire_rrd),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    // Retire monitor: each pulse must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        if (!rst && retire_valid) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected_retire: got rd=%0d rrd=%0d, expected no retire", retire_rd, retire_rrd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({retire_rd, retire_rrd, push_free_reg, freed_reg} !== {e.rd, e.rrd, e.push, e.freed}) begin
                    tests_failed++;
                    $display("FAIL sb_retire: got rd=%0d rrd=%0d push=%0b freed=%0d, expected rd=%0d rrd=%0d push=%0b freed=%0d",
                             retire_rd, retire_rrd, push_free_reg, freed_reg, e.rd, e.rrd, e.push, e.freed);
                end
            end
        end else if (!rst && push_free_reg) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_orphan_push: got push_free_reg=1 freed=%0d without retire_valid", freed_reg);
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_dispatch(input bit rw, input logic [4:0] rd, input logic [5:0] rrd,
                               input logic [5:0] old, output logic [3:0] idx, output bit acc);
        disp_valid = 1'b1; disp_reg_write = rw; disp_rd = rd; disp_rrd = rrd; disp_old_tag = old;
        acc = disp_ready;
        idx = disp_rob_idx;
        if (acc) sb.push_back('{rd, rrd, (rw && rd != 0), ((rw && rd != 0) ? old : 6'd0)});
        @(negedge clk);
        disp_valid = 1'b0;
    endtask

    task automatic complete(input int port, input logic [3:0] idx);
        if (port == 0) begin cmpl0_valid = 1'b1; cmpl0_idx = idx; end
        else           begin cmpl1_valid = 1'b1; cmpl1_idx = idx; end
        @(negedge clk);
        cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!(empty && !retire_valid) && n < 100) begin @(negedge clk); n++; end
        tests_run++;
        if (!empty) begin
            tests_failed++;
            $display("FAIL %s_drain_timeout: got count=%0d, expected 0", name, count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({empty, count, disp_ready, retire_valid, push_free_reg, freed_reg, retire_rd, retire_rrd} !==
            {1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, 6'd0}) begin
            tests_failed++;
            $display("FAIL reset_in: got empty=%0b count=%0d ready=%0b rv=%0b push=%0b, expected 1 0 1 0 0",
                     empty, count, disp_ready, retire_valid, push_free_reg);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({empty, count, disp_ready, disp_rob_idx} !== {1'b1, 5'd0, 1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL reset_out: got empty=%0b count=%0d ready=%0b idx=%0d, expected 1 0 1 0",
                     empty, count, disp_ready, disp_rob_idx);
        end
    endtask

    task automatic test_in_order();
        logic [3:0] idx; bit acc;
        do_dispatch(1'b1, 5'd5, 6'd32, 6'd5, idx, acc);
        tests_run++;
        if (!acc || idx !== 4'd0) begin
            tests_failed++; $display("FAIL inorder_accept: got acc=%0b idx=%0d, expected 1 0", acc, idx);
        end
        complete(0, idx);
        tests_run++;
        if (retire_valid !== 1'b0) begin
            tests_failed++; $display("FAIL inorder_early: got retire_valid=%0b one edge after done, expected 0", retire_valid);
        end
        @(negedge clk);
        tests_run++;
        if ({retire_valid, push_free_reg, freed_reg, retire_rrd, retire_rd} !== {1'b1, 1'b1, 6'd5, 6'd32, 5'd5}) begin
            tests_failed++;
            $display("FAIL inorder_retire: got rv=%0b push=%0b freed=%0d rrd=%0d rd=%0d, expected 1 1 5 32 5",
                     retire_valid, push_free_reg, freed_reg, retire_rrd, retire_rd);
        end
        @(negedge clk);
        tests_run++;
        if ({retire_valid, push_free_reg, empty} !== 3'b001) begin
            tests_failed++;
            $display("FAIL inorder_pulse: got rv=%0b push=%0b empty=%0b, expected 0 0 1", retire_valid, push_free_reg, empty);
        end
    endtask

    task automatic test_out_of_order();
        logic [3:0] idx [3]; bit acc;
        for (int i = 0; i < 3; i++) do_dispatch(1'b1, 5'(i + 1), 6'(40 + i), 6'(10 + i), idx[i], acc);
        complete(1, idx[2]);
        complete(0, idx[1]);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (retire_valid !== 1'b0) begin
                tests_failed++; $display("FAIL ooo_blocked: got retire_valid=%0b while head incomplete, expected 0", retire_valid);
            end
        end
        complete(0, idx[0]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (retire_valid !== 1'b1 || retire_rrd !== 6'(40 + k)) begin
                tests_failed++;
                $display("FAIL ooo_retire%0d: got rv=%0b rrd=%0d, expected 1 %0d", k, retire_valid, retire_rrd, 40 + k);
            end
        end
        @(negedge clk);
        tests_run++;
        if (retire_valid !== 1'b0 || count !== 5'd0) begin
            tests_failed++; $display("FAIL ooo_after: got rv=%0b count=%0d, expected 0 0", retire_valid, count);
        end
    endtask

    task automatic test_no_free();
        logic [3:0] ia, ib; bit acc;
        do_dispatch(1'b0, 5'd7, 6'd20, 6'd7, ia, acc);
        do_dispatch(1'b1, 5'd0, 6'd21, 6'd9, ib, acc);
        cmpl0_valid = 1'b1; cmpl0_idx = ia; cmpl1_valid = 1'b1; cmpl1_idx = ib;
        @(negedge clk);
        cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({retire_valid, push_free_reg, freed_reg} !== {1'b1, 1'b0, 6'd0}) begin
                tests_failed++;
                $display("FAIL nofree%0d: got rv=%0b push=%0b freed=%0d, expected 1 0 0", k, retire_valid, push_free_reg, freed_reg);
            end
        end
        wait_empty("nofree");
    endtask

    task automatic test_reset_mid();
        logic [3:0] ia, ib; bit acc;
        do_dispatch(1'b1, 5'd6, 6'd33, 6'd6, ia, acc);
        do_dispatch(1'b1, 5'd8, 6'd34, 6'd8, ib, acc);
        complete(0, ia);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        tests_run++;
        if ({empty, count, disp_ready, retire_valid, push_free_reg} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midrst_async: got empty=%0b count=%0d ready=%0b rv=%0b push=%0b, expected 1 0 1 0 0",
                     empty, count, disp_ready, retire_valid, push_free_reg);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if ({push_free_reg, retire_valid, empty, count} !== {1'b0, 1'b0, 1'b1, 5'd0}) begin
                tests_failed++;
                $display("FAIL midrst_after%0d: got push=%0b rv=%0b empty=%0b count=%0d, expected 0 0 1 0",
                         i, push_free_reg, retire_valid, empty, count);
            end
        end
    endtask

    task automatic test_full_wrap();
        logic [3:0] idx; bit acc;
        for (int i = 0; i < DEPTH; i++) begin
            do_dispatch(1'b1, 5'(i + 1), 6'(i + 16), 6'(i), idx, acc);
            tests_run++;
            if (!acc || idx !== 4'(i) || count > 5'd16) begin
                tests_failed++;
                $display("FAIL full_fill%0d: got acc=%0b idx=%0d count=%0d, expected 1 %0d <=16", i, acc, idx, count, i);
            end
        end
        tests_run++;
        if (disp_ready !== 1'b0 || count !== 5'd16) begin
            tests_failed++; $display("FAIL full_flag: got ready=%0b count=%0d, expected 0 16", disp_ready, count);
        end
        do_dispatch(1'b1, 5'd30, 6'd63, 6'd30, idx, acc);
        tests_run++;
        if (acc || count !== 5'd16) begin
            tests_failed++; $display("FAIL full_17th: got acc=%0b count=%0d, expected 0 16", acc, count);
        end
        complete(0, 4'd0);
        // Head retires on the next edge; dispatch in that same cycle must still be refused.
        do_dispatch(1'b1, 5'd9, 6'd60, 6'd9, idx, acc);
        tests_run++;
        if (acc || retire_valid !== 1'b1 || count !== 5'd15 || disp_ready !== 1'b1 || disp_rob_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL full_retire_same: got acc=%0b rv=%0b count=%0d ready=%0b idx=%0d, expected 0 1 15 1 0",
                     acc, retire_valid, count, disp_ready, disp_rob_idx);
        end
        do_dispatch(1'b1, 5'd10, 6'd61, 6'd10, idx, acc);
        tests_run++;
        if (!acc || idx !== 4'd0 || count !== 5'd16 || disp_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_land: got acc=%0b idx=%0d count=%0d ready=%0b, expected 1 0 16 0", acc, idx, count, disp_ready);
        end
        for (int i = 1; i < DEPTH; i += 2) begin
            cmpl0_valid = 1'b1; cmpl0_idx = 4'(i);
            cmpl1_valid = 1'b1; cmpl1_idx = 4'((i + 1) % DEPTH);
            @(negedge clk);
            tests_run++;
            if (count > 5'd16) begin
                tests_failed++; $display("FAIL wrap_count: got count=%0d, expected <=16", count);
            end
        end
        cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
        wait_empty("wrap");
    endtask

    task automatic test_simultaneous();
        logic [3:0] ia, ib; bit acc;
        do_dispatch(1'b1, 5'd3, 6'd50, 6'd30, ia, acc);
        cmpl0_valid = 1'b1; cmpl0_idx = ia; cmpl1_valid = 1'b1; cmpl1_idx = ia;
        @(negedge clk);
        cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
        do_dispatch(1'b1, 5'd4, 6'd51, 6'd31, ib, acc);
        tests_run++;
        if (!acc || retire_valid !== 1'b1 || retire_rrd !== 6'd50 || count !== 5'd1) begin
            tests_failed++;
            $display("FAIL simul_retire_disp: got acc=%0b rv=%0b rrd=%0d count=%0d, expected 1 1 50 1",
                     acc, retire_valid, retire_rrd, count);
        end
        @(negedge clk);
        tests_run++;
        if (retire_valid !== 1'b0 || count !== 5'd1) begin
            tests_failed++; $display("FAIL simul_single: got rv=%0b count=%0d, expected 0 1", retire_valid, count);
        end
        complete(1, ib);
        wait_empty("simul");
    endtask

    task automatic test_dispatch_complete_tail();
        logic [3:0] idx;
        idx = disp_rob_idx;
        disp_valid = 1'b1; disp_reg_write = 1'b1; disp_rd = 5'd12; disp_rrd = 6'd44; disp_old_tag = 6'd12;
        cmpl0_valid = 1'b1; cmpl0_idx = idx;
        sb.push_back('{5'd12, 6'd44, 1'b1, 6'd12});
        @(negedge clk);
        disp_valid = 1'b0; cmpl0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (retire_valid !== 1'b0 || count !== 5'd1) begin
                tests_failed++;
                $display("FAIL tail_cmpl_ignored%0d: got rv=%0b count=%0d, expected 0 1", i, retire_valid, count);
            end
        end
        complete(0, idx);
        wait_empty("tail_cmpl");
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_no_free();
        test_reset_mid();
        test_full_wrap();
        test_simultaneous();
        test_dispatch_complete_tail();
        repeat (2) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++; $display("FAIL sb_leftover: got %0d outstanding retires, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion by 200000, expected finish");
        $fatal(1, "timeout");
    end

endmodule
